// File: rtl/ism330_spi_reader.sv
// SPI mode-3 read master for the ISM330DHCX: sends one read command and
// collects two auto-incremented bytes, returned as {high byte, low byte}.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | CS high, waiting for start
// SETUP | CS low, SCK high, CS-to-first-SCK-fall delay
// LOW   | SCK low half-period, MOSI carries the current bit
// HIGH  | SCK high half-period, MISO sampled on entry
// HOLD  | last SCK rise to CS rise delay
// GAP   | CS high, minimum deselect time before busy drops
module ism330_spi_reader #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic        rp2350_clk,
    input  logic        rp2350_rst_n,
    input  logic        start,
    input  logic [6:0]  reg_addr,
    output logic        busy,
    output logic        rp2350_sck,
    output logic        rp2350_cs,
    output logic        rp2350_mosi,
    input  logic        rp2350_miso,
    output logic [15:0] rd_data,
    output logic        rd_valid
);

    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_M1 = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_M1  = 8'(CS_HOLD - 1);
    localparam logic [7:0] GAP_M1   = 8'(CS_GAP - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [23:0] sout_q, sout_d;
    logic [15:0] sin_q, sin_d;
    logic        sck_q, sck_d;
    logic        cs_q, cs_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;

    // State and every output register; reset drops everything to idle at once.
    always_ff @(posedge rp2350_clk or negedge rp2350_rst_n) begin
        if (!rp2350_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            sout_q     <= '0;
            sin_q      <= '0;
            sck_q      <= 1'b1;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sout_q     <= sout_d;
            sin_q      <= sin_d;
            sck_q      <= sck_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Next-state and next-output logic; the down-counter ends each phase at zero.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        sout_d     = sout_q;
        sin_d      = sin_q;
        sck_d      = sck_q;
        cs_d       = cs_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_M1;
                    bit_d   = '0;
                    sout_d  = {1'b1, reg_addr, 16'h0000};
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = LOW;
                    cnt_d   = DIV_M1;
                    sck_d   = 1'b0;
                    mosi_d  = sout_q[23];
                    sout_d  = {sout_q[22:0], 1'b0};
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            LOW: begin
                if (cnt_q == 8'd0) begin
                    state_d = HIGH;
                    cnt_d   = DIV_M1;
                    sck_d   = 1'b1;
                    // The first eight bits are the command; MISO is meaningless there.
                    if (bit_q >= 5'd8) begin
                        sin_d = {sin_q[14:0], rp2350_miso};
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HIGH: begin
                if (cnt_q == 8'd0) begin
                    if (bit_q == 5'd23) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_M1;
                    end else begin
                        state_d = LOW;
                        cnt_d   = DIV_M1;
                        bit_d   = bit_q + 5'd1;
                        sck_d   = 1'b0;
                        mosi_d  = sout_q[23];
                        sout_d  = {sout_q[22:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d    = GAP;
                    cnt_d      = GAP_M1;
                    cs_d       = 1'b1;
                    // Sensor sends the low byte first, so it sits in the upper half here.
                    rd_data_d  = {sin_q[7:0], sin_q[15:8]};
                    rd_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = busy_q;
    assign rp2350_sck  = sck_q;
    assign rp2350_cs   = cs_q;
    assign rp2350_mosi = mosi_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_ism330_spi_reader.sv
// Bench for ism330_spi_reader: directed reads against a mode-3 sensor model,
// with a scoreboard queue checked by a monitor whenever rd_valid is seen.
module tb_ism330_spi_reader;

    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_GAP   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  reg_addr = '0;
    logic        busy, sck, cs, mosi;
    logic        miso = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;

    ism330_spi_reader #(
        .CLK_DIV (CLK_DIV),
        .CS_SETUP(CS_SETUP),
        .CS_HOLD (CS_HOLD),
        .CS_GAP  (CS_GAP)
    ) dut (
        .rp2350_clk  (clk),
        .rp2350_rst_n(rst_n),
        .start       (start),
        .reg_addr    (reg_addr),
        .busy        (busy),
        .rp2350_sck  (sck),
        .rp2350_cs   (cs),
        .rp2350_mosi (mosi),
        .rp2350_miso (miso),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid)
    );

    always #5 clk = ~clk;

    // Sensor model: command-phase filler, then low byte, then high byte, MSB first,
    // each bit presented on the SCK falling edge.
    logic [23:0] tx_word = '0;
    int          tx_idx  = 0;
    always @(negedge sck or negedge cs) begin
        if (sck) begin
            tx_idx = 0;
        end else begin
            if (tx_idx < 24) miso = tx_word[23 - tx_idx];
            tx_idx = tx_idx + 1;
        end
    end

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];

    int          cyc = 0;
    int          cs_falls = 0, cs_fall_cyc = 0, cs_rise_cyc = 0;
    int          lo_len = 0, hi_len = 0, cs_low_len = 0;
    int          sck_falls = 0, first_fall_cyc = 0;
    int          busy_fall_cyc = 0, valid_cyc = 0, valid_count = 0;
    logic [23:0] mosi_word = '0;
    int          gap_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic p_cs, p_sck, p_busy;
        logic [15:0] e;
        p_cs = 1'b1; p_sck = 1'b1; p_busy = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                p_cs = 1'b1; p_sck = 1'b1; p_busy = 1'b0;
                continue;
            end
            if (p_cs && !cs) begin
                cs_fall_cyc = cyc; cs_falls++; gap_log.push_back(hi_len);
                lo_len = 0; sck_falls = 0; mosi_word = '0;
            end
            if (!p_cs && cs) begin
                cs_rise_cyc = cyc; cs_low_len = lo_len; hi_len = 0;
            end
            if (!cs) lo_len++; else hi_len++;
            if (!cs && p_sck && !sck) begin
                sck_falls++;
                if (sck_falls == 1) first_fall_cyc = cyc;
            end
            if (!cs && !p_sck && sck) mosi_word = {mosi_word[22:0], mosi};
            if (p_busy && !busy) busy_fall_cyc = cyc;
            if (rd_valid) begin
                valid_cyc = cyc;
                valid_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected rd_valid", 32'(rd_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(e));
                    chk("rd_valid on cs rise", cs_rise_cyc, cyc);
                end
            end
            p_cs = cs; p_sck = sck; p_busy = busy;
        end
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("busy drop within bound", 32'(busy), 0);
    endtask

    task automatic launch(input logic [6:0] a, input logic [7:0] lo, input logic [7:0] hi);
        tx_word = {8'hA5, lo, hi};
        @(negedge clk);
        start = 1'b1;
        reg_addr = a;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int base_v, base_f, n;
        fork
            monitor();
        join_none

        // 1: asynchronous reset values and quiet idle
        #2 rst_n = 1'b0;
        #1;
        chk("reset cs", 32'(cs), 1);
        chk("reset sck", 32'(sck), 1);
        chk("reset mosi", 32'(mosi), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset rd_valid", 32'(rd_valid), 0);
        chk("reset rd_data", 32'(rd_data), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1 chk("idle outputs", 32'({cs, sck, mosi, busy, rd_valid}), 32'b11000);
        end

        // 2: basic read
        exp_q.push_back(16'h1234);
        launch(7'h22, 8'h34, 8'h12);
        wait_idle(300);
        #1;
        chk("cs low cycles", cs_low_len, 100);
        chk("sck falls", sck_falls, 24);
        chk("mosi bits", 32'(mosi_word), 32'hA20000);
        chk("setup delay", first_fall_cyc - cs_fall_cyc, CS_SETUP);
        chk("busy fall after valid", busy_fall_cyc - valid_cyc, CS_GAP);

        // 3: signed data
        exp_q.push_back(16'h80FF);
        launch(7'h0A, 8'hFF, 8'h80);
        wait_idle(300);
        #1 chk("mosi bits 0x0A", 32'(mosi_word), 32'h8A0000);

        // 4: start ignored while busy, then accepted on first idle cycle
        base_v = valid_count;
        base_f = cs_falls;
        exp_q.push_back(16'h2211);
        launch(7'h24, 8'h11, 8'h22);
        repeat (30) @(negedge clk);
        start = 1'b1; reg_addr = 7'h28;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!cs && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("cs rise within bound", 32'(cs), 1);
        @(negedge clk);
        start = 1'b1; reg_addr = 7'h28;
        @(negedge clk);
        start = 1'b0;
        wait_idle(50);
        tx_word = {8'hA5, 8'h55, 8'h66};
        exp_q.push_back(16'h6655);
        start = 1'b1; reg_addr = 7'h28;
        #1;
        chk("ignored starts: one valid", valid_count - base_v, 1);
        chk("ignored starts: one cs fall", cs_falls - base_f, 1);
        chk("latched addr 0x24", 32'(mosi_word), 32'hA40000);
        @(negedge clk);
        start = 1'b0;
        #1 chk("accept on first idle edge", cs_fall_cyc - busy_fall_cyc, 1);
        wait_idle(300);
        #1 chk("mosi bits 0x28", 32'(mosi_word), 32'hA80000);

        // 5: reset mid-transfer
        base_v = valid_count;
        launch(7'h11, 8'h77, 8'h88);
        n = 0;
        while (sck_falls < 11 && n < 300) begin
            @(negedge clk);
            #1 n++;
        end
        chk("reached bit 10", 32'(sck_falls >= 11), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort cs", 32'(cs), 1);
        chk("abort sck", 32'(sck), 1);
        chk("abort busy", 32'(busy), 0);
        chk("abort rd_valid", 32'(rd_valid), 0);
        chk("abort rd_data", 32'(rd_data), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk("no valid from aborted read", valid_count - base_v, 0);
        exp_q.push_back(16'h8877);
        launch(7'h11, 8'h77, 8'h88);
        wait_idle(300);

        // 6: back-to-back with start held high
        base_v = valid_count;
        base_f = cs_falls;
        tx_word = {8'hA5, 8'hCD, 8'hAB};
        repeat (3) exp_q.push_back(16'hABCD);
        @(negedge clk);
        start = 1'b1; reg_addr = 7'h33;
        n = 0;
        while (cs_falls < base_f + 3 && n < 1000) begin
            @(negedge clk);
            #1 n++;
        end
        start = 1'b0;
        chk("three transactions started", cs_falls - base_f, 3);
        wait_idle(300);
        repeat (2) @(negedge clk);
        #1;
        chk("b2b valid count", valid_count - base_v, 3);
        if (gap_log.size() >= 2) begin
            chk("b2b gap 1", gap_log[gap_log.size() - 2], CS_GAP + 1);
            chk("b2b gap 2", gap_log[gap_log.size() - 1], CS_GAP + 1);
        end else begin
            chk("b2b gap log size", gap_log.size(), 2);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ism330_spi_reader.md
Name: ism330_spi_reader

Overview:
- SPI mode-3 master that generates the chip select, serial clock and data-out lines to the ISM330DHCX.
- Each transaction issues one register-read command, then clocks in two data bytes (low byte first, via sensor address auto-increment) on the MISO line.
- Presents the result as a 16-bit big-endian signed word with a one-cycle valid pulse.
- Sits between the system sequencer (which requests axis reads) and the sensor pins; its SCK, CS and MISO lines are the same lines the deserializer side listens on.

Parameters:
- CLK_DIV, 4: system clocks per SCK half-period; legal range 1..255.
- CS_SETUP, 2: system clocks between CS falling and the first SCK falling edge; legal range 1..255.
- CS_HOLD, 2: system clocks between the last SCK rising edge and CS rising; legal range 1..255.
- CS_GAP, 4: minimum system clocks CS stays high after a transaction before `busy` drops; legal range 1..255.

Ports:
- rp2350_clk, input, 1: system clock; all logic on its rising edge.
- rp2350_rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: transaction request; sampled only while idle.
- reg_addr, input, 7: sensor register address of the low byte.
- busy, output, 1: high from acceptance until the gap completes.
- rp2350_sck, output, 1: SPI clock; idles high.
- rp2350_cs, output, 1: chip select, active low; idles high.
- rp2350_mosi, output, 1: SPI data to sensor.
- rp2350_miso, input, 1: SPI data from sensor.
- rd_data, output, 16: last word read, {high byte, low byte}.
- rd_valid, output, 1: one-cycle pulse when rd_data updates.

Behaviour:
- Reset (asynchronous, active low): rp2350_cs=1, rp2350_sck=1, rp2350_mosi=0, busy=0, rd_valid=0, rd_data=0, state=IDLE, all counters 0.
  - Reset asserted mid-transaction aborts immediately with these values; no partial rd_data update and no rd_valid.
- All outputs are registered.
- State machine: IDLE -> SETUP -> (LOW <-> HIGH, 24 bits) -> HOLD -> GAP -> IDLE.
- IDLE: if start=1 at edge k, then at edge k:
  - reg_addr is latched.
  - The 24-bit shift-out word becomes {1'b1, reg_addr, 16'h0000} (read bit = 1).
  - rp2350_cs goes to 0 and busy goes to 1; the state moves to SETUP.
  - start is ignored in every non-IDLE state, with no queuing.
- SETUP: lasts CS_SETUP cycles; SCK stays high.
- LOW: at entry, rp2350_sck goes to 0 and rp2350_mosi is driven with the current MSB of the shift-out word. The state lasts CLK_DIV cycles.
- HIGH: at entry, rp2350_sck goes to 1 and rp2350_miso is sampled into the shift-in register LSB (MSB-first within each byte). The state lasts CLK_DIV cycles.
  - After the HIGH phase of bit 24 the state moves to HOLD; otherwise it returns to LOW with the next bit.
- MOSI: outputs 0 for all 16 data bits and keeps its last value outside LOW/HIGH.
- MISO: samples taken during the 8 command bits are discarded.
- Shift-in register: 16 bits. The first received byte is the low byte, the second the high byte.
- HOLD: SCK stays high for CS_HOLD cycles. At the edge that ends HOLD:
  - rp2350_cs goes to 1.
  - rd_data takes {second byte, first byte}.
  - rd_valid goes to 1 for exactly one cycle.
- GAP: lasts CS_GAP cycles; busy goes to 0 at the edge that ends GAP.
  - A start on the next edge is accepted.
- Timing with acceptance at edge k:
  - First SCK fall at k+CS_SETUP.
  - CS rise and rd_valid at k+CS_SETUP+48*CLK_DIV+CS_HOLD.
  - busy falls CS_GAP cycles after that.
- Counters:
  - The bit counter runs 0..23 and wraps only via a new transaction.
  - The divider counter reloads on every phase change.
- rd_data holds its value between transactions.

Test Plan:
1. Reset values: assert rp2350_rst_n=0 -> cs=1, sck=1, mosi=0, busy=0, rd_valid=0, rd_data=0 asynchronously. Release and hold for 10 cycles -> no toggling.
2. Basic read: CLK_DIV=2, CS_SETUP=2, CS_HOLD=2, CS_GAP=4, start with reg_addr=0x22, sensor model returns 0x34 then 0x12.
   - CS is low for exactly 100 cycles and there are 24 SCK falling edges.
   - MOSI reads 1,0,1,0,0,0,1,0 then sixteen 0s.
   - rd_data=0x1234 with a single-cycle rd_valid on the CS-rise edge; busy falls 4 cycles later.
3. Signed data: model returns 0xFF then 0x80 -> rd_data=0x80FF.
4. Start ignored while busy: pulse start with reg_addr=0x28 mid-transfer and during GAP -> no second transaction and latched address unchanged. Start on the first idle cycle -> accepted at that edge.
5. Reset mid-transfer: assert reset after bit 10 -> cs=1, sck=1 immediately, no rd_valid, rd_data keeps its reset value 0. A new start after release completes normally.
6. Back-to-back: start held high continuously -> consecutive transactions are separated by exactly CS_GAP+1 cycles of CS high, and each produces one rd_valid.
